// File: rtl/iir_sample_capture.sv
// Capture buffer for the iir_filter output stream: records one block of samples once
// armed, tracks peak magnitude and rail clips, then serves the block through a registered read port.
module iir_sample_capture #(
  parameter int DATA_W = 16,
  parameter int DEPTH  = 1024,
  parameter int ADDR_W = $clog2(DEPTH)
) (
  input  logic              clk,
  input  logic              rst,
  input  logic [DATA_W-1:0] y_in,
  input  logic              y_valid,
  input  logic              arm,
  output logic              busy,
  output logic              done,
  output logic [ADDR_W:0]   count,
  output logic [DATA_W-1:0] peak_abs,
  output logic [ADDR_W:0]   clip_cnt,
  input  logic              rd_en,
  input  logic [ADDR_W-1:0] rd_addr,
  output logic [DATA_W-1:0] rd_data,
  output logic              rd_valid,
  output logic [1:0]        state_dbg
);

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    CAPTURE = 2'd1,
    DONE    = 2'd2
  } state_t;

  localparam logic [ADDR_W:0]   LAST_IDX = (ADDR_W + 1)'(DEPTH - 1);
  localparam logic [ADDR_W:0]   DEPTH_C  = (ADDR_W + 1)'(DEPTH);
  localparam logic [ADDR_W:0]   ONE      = (ADDR_W + 1)'(1);
  localparam logic [DATA_W-1:0] POS_MAX  = {1'b0, {(DATA_W - 1){1'b1}}};
  localparam logic [DATA_W-1:0] NEG_MIN  = {1'b1, {(DATA_W - 1){1'b0}}};

  state_t            state, state_next;
  logic [DATA_W-1:0] mem [DEPTH];
  logic [DATA_W-1:0] y_abs;
  logic              is_clip;
  logic              accept;
  logic              start;
  logic              rd_fire;
  logic              rd_in_range;

  // Magnitude with the most-negative code pinned to +max so it fits DATA_W unsigned.
  always_comb begin
    y_abs = y_in;
    if (y_in == NEG_MIN) begin
      y_abs = POS_MAX;
    end else if (y_in[DATA_W-1]) begin
      y_abs = -y_in;
    end
  end

  // Handshakes: y_valid qualifies y_in for exactly one cycle with no backpressure;
  // rd_en is accepted only in DONE and answered by a one-cycle rd_valid pulse one cycle later.
  assign is_clip     = (y_in == POS_MAX) || (y_in == NEG_MIN);
  assign accept      = (state == CAPTURE) && y_valid;
  assign start       = (state != CAPTURE) && arm;
  assign rd_fire     = (state == DONE) && rd_en;
  assign rd_in_range = ({1'b0, rd_addr} < DEPTH_C);

  always_comb begin
    state_next = state;
    case (state)
      IDLE:    if (arm) state_next = CAPTURE;
      CAPTURE: if (y_valid && (count == LAST_IDX)) state_next = DONE;
      DONE:    if (arm) state_next = CAPTURE;
      default: state_next = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state    <= IDLE;
      count    <= '0;
      peak_abs <= '0;
      clip_cnt <= '0;
    end else begin
      state <= state_next;
      if (start) begin
        count    <= '0;
        peak_abs <= '0;
        clip_cnt <= '0;
      end else if (accept) begin
        count <= count + ONE;
        if (y_abs > peak_abs) peak_abs <= y_abs;
        if (is_clip) clip_cnt <= clip_cnt + ONE;
      end
    end
  end

  // Storage is never cleared so it maps onto block RAM.
  always_ff @(posedge clk) begin
    if (accept) mem[count[ADDR_W-1:0]] <= y_in;
  end

  // Reads are gated by the current state, so a read issued alongside arm sees pre-arm data.
  always_ff @(posedge clk) begin
    if (rst) begin
      rd_data  <= '0;
      rd_valid <= 1'b0;
    end else begin
      rd_valid <= rd_fire;
      if (rd_fire) rd_data <= rd_in_range ? mem[rd_addr] : '0;
    end
  end

  assign busy      = (state == CAPTURE);
  assign done      = (state == DONE);
  assign state_dbg = state;

endmodule

// File: tb/tb_iir_sample_capture.sv
// Directed bench for iir_sample_capture at DEPTH=8: status checks inline, read data
// checked by a negedge monitor against an expected-value queue.
module tb_iir_sample_capture;

  localparam int DATA_W = 16;
  localparam int DEPTH  = 8;
  localparam int ADDR_W = 3;

  logic              clk = 1'b0;
  logic              rst;
  logic [DATA_W-1:0] y_in;
  logic              y_valid;
  logic              arm;
  logic              busy;
  logic              done;
  logic [ADDR_W:0]   count;
  logic [DATA_W-1:0] peak_abs;
  logic [ADDR_W:0]   clip_cnt;
  logic              rd_en;
  logic [ADDR_W-1:0] rd_addr;
  logic [DATA_W-1:0] rd_data;
  logic              rd_valid;
  logic [1:0]        state_dbg;

  int checks = 0;
  int errors = 0;
  logic [DATA_W-1:0] exp_q[$];
  logic [DATA_W-1:0] cap[DEPTH];
  logic [DATA_W-1:0] last_rd = '0;

  int v1[8] = '{1, -2, 3, -4, 5, -6, 7, -8};
  int v2[8] = '{32767, -32768, 10, -32768, -5, 100, -200, 7};
  int v3[4] = '{11, -22, 33, -44};
  int v4[8] = '{50, -60, 70, -80, 90, -100, 110, -32767};
  int v5[8] = '{1000, -1001, 1002, -1003, 1004, -1005, 1006, -1007};

  iir_sample_capture #(.DATA_W(DATA_W), .DEPTH(DEPTH)) dut (
    .clk(clk), .rst(rst), .y_in(y_in), .y_valid(y_valid), .arm(arm),
    .busy(busy), .done(done), .count(count), .peak_abs(peak_abs), .clip_cnt(clip_cnt),
    .rd_en(rd_en), .rd_addr(rd_addr), .rd_data(rd_data), .rd_valid(rd_valid),
    .state_dbg(state_dbg)
  );

  // Clock and reset-free timebase; inputs change 1 ns after each rising edge.
  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got %0d exp %0d", name, got, exp);
    end
  endtask

  task automatic feed(input int v, input int idx);
    y_valid = 1'b1;
    y_in    = 16'(v);
    cap[idx] = 16'(v);
    tick();
    y_valid = 1'b0;
  endtask

  task automatic arm_cap();
    arm = 1'b1;
    tick();
    arm = 1'b0;
  endtask

  task automatic read(input int a);
    rd_en   = 1'b1;
    rd_addr = 3'(a);
    exp_q.push_back(cap[a]);
    last_rd = cap[a];
    tick();
    rd_en = 1'b0;
    check("rd_valid_pulse", 32'(rd_valid), 1);
  endtask

  task automatic check_status(input int exp_done, input int exp_count, input int exp_peak,
                              input int exp_clip);
    check("done", 32'(done), 32'(exp_done));
    check("count", 32'(count), 32'(exp_count));
    check("peak_abs", 32'(peak_abs), 32'(exp_peak));
    check("clip_cnt", 32'(clip_cnt), 32'(exp_clip));
  endtask

  // Scoreboard monitor: every rd_valid pulse must match the oldest expected read.
  always @(negedge clk) begin
    if (rd_valid) begin
      checks++;
      if (exp_q.size() == 0) begin
        errors++;
        $display("FAIL rd_valid_unexpected got data %0d exp no read", rd_data);
      end else begin
        logic [DATA_W-1:0] e;
        e = exp_q.pop_front();
        if (rd_data !== e) begin
          errors++;
          $display("FAIL rd_data got %0d exp %0d", rd_data, e);
        end
      end
    end
  end

  initial begin
    rst = 1'b1; arm = 1'b0; y_valid = 1'b0; y_in = '0; rd_en = 1'b0; rd_addr = '0;

    // Reset and idle
    repeat (10) tick();
    check("rst_busy", 32'(busy), 0);
    check("rst_state", 32'(state_dbg), 0);
    check("rst_rd_data", 32'(rd_data), 0);
    check("rst_rd_valid", 32'(rd_valid), 0);
    check_status(0, 0, 0, 0);
    rst = 1'b0;
    for (int i = 0; i < 5; i++) begin
      y_valid = 1'b1;
      y_in    = 16'(i * 1000 + 7);
      tick();
    end
    y_valid = 1'b0;
    check("idle_busy", 32'(busy), 0);
    check_status(0, 0, 0, 0);

    // Full capture with continuous valid
    arm_cap();
    check("arm_busy", 32'(busy), 1);
    check("arm_count", 32'(count), 0);
    for (int i = 0; i < 8; i++) begin
      feed(v1[i], i);
      check("cap_count", 32'(count), 32'(i + 1));
      if (i < 7) check("done_early", 32'(done), 0);
    end
    check("full_busy", 32'(busy), 0);
    check_status(1, 8, 8, 0);
    for (int a = 0; a < 8; a++) read(a);
    tick();
    check("rd_valid_idle", 32'(rd_valid), 0);

    // Gapped stream with rail-clipped samples
    arm_cap();
    for (int i = 0; i < 8; i++) begin
      feed(v2[i], i);
      if (i < 7) begin
        y_in = 16'hbeef;
        tick();
        check("gap_done_early", 32'(done), 0);
      end
    end
    check_status(1, 8, 32767, 3);
    y_valid = 1'b1;
    y_in    = 16'd5;
    tick();
    y_valid = 1'b0;
    check("done_ignores_valid_count", 32'(count), 8);
    check("done_ignores_valid_done", 32'(done), 1);
    for (int a = 0; a < 8; a++) read(a);

    // Arm and valid in the same cycle: that sample is dropped
    arm = 1'b1; y_valid = 1'b1; y_in = 16'd100;
    tick();
    arm = 1'b0; y_valid = 1'b0;
    check("armvalid_busy", 32'(busy), 1);
    check("armvalid_count", 32'(count), 0);
    feed(200, 0);
    for (int i = 1; i < 8; i++) feed(i, i);
    check_status(1, 8, 200, 0);
    read(0);
    read(1);

    // Reset mid-capture, then a fresh capture
    arm_cap();
    for (int i = 0; i < 4; i++) feed(v3[i], i);
    check("partial_count", 32'(count), 4);
    rst = 1'b1;
    tick();
    rst = 1'b0;
    last_rd = '0;
    check("midrst_busy", 32'(busy), 0);
    check("midrst_rd_data", 32'(rd_data), 0);
    check_status(0, 0, 0, 0);
    arm_cap();
    for (int i = 0; i < 8; i++) feed(v4[i], i);
    check_status(1, 8, 32767, 0);
    for (int a = 0; a < 8; a++) read(a);

    // Read gating during CAPTURE, then read together with re-arm
    arm_cap();
    for (int i = 0; i < 3; i++) feed(v5[i], i);
    rd_en = 1'b1; rd_addr = 3'd2;
    tick();
    rd_en = 1'b0;
    check("capture_rd_valid", 32'(rd_valid), 0);
    check("capture_rd_hold", 32'(rd_data), 32'(last_rd));
    for (int i = 3; i < 8; i++) feed(v5[i], i);
    check_status(1, 8, 1007, 0);
    rd_en = 1'b1; rd_addr = 3'd2; arm = 1'b1;
    exp_q.push_back(cap[2]);
    tick();
    rd_en = 1'b0; arm = 1'b0;
    check("rearm_rd_valid", 32'(rd_valid), 1);
    check("rearm_busy", 32'(busy), 1);

    tick();
    tick();
    check("exp_q_empty", 32'(exp_q.size()), 0);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/iir_sample_capture.md
# iir_sample_capture

Capture buffer on the output side of `iir_filter`: sinks the `y_out`/`y_valid` sample stream into on-chip memory once armed. It then serves the captured block to a reader through a registered read port. It also tracks peak magnitude and rail-clipped samples for bring-up. It replaces file-based output logging when the filter runs on hardware.

## Interface
- `DATA_W`, 16, sample width (signed two's complement)
- `DEPTH`, 1024, samples per capture; any value ≥ 2
- `ADDR_W`, `$clog2(DEPTH)`, derived, not overridden
- `clk`  in  1  single clock; all logic rising-edge
- `rst`  in  1  synchronous, active-high reset
- `y_in`  in  DATA_W  filter output sample, signed
- `y_valid`  in  1  `y_in` qualifier; one sample per high cycle, no backpressure
- `arm`  in  1  start a capture (level sampled each cycle)
- `busy`  out  1  high in CAPTURE
- `done`  out  1  high in DONE (buffer full and readable)
- `count`  out  ADDR_W+1  samples stored in current capture
- `peak_abs`  out  DATA_W  max |sample| captured, unsigned
- `clip_cnt`  out  ADDR_W+1  samples equal to +max or −min of DATA_W
- `rd_en`  in  1  read request
- `rd_addr`  in  ADDR_W  read index
- `rd_data`  out  DATA_W  read sample, signed
- `rd_valid`  out  1  `rd_data` qualifier, one-cycle pulse

## Operation
- States: IDLE, CAPTURE, DONE.
- **IDLE**
  - `arm`=1 → CAPTURE.
  - On that transition, `count`, `peak_abs` and `clip_cnt` clear to 0.
- **CAPTURE**
  - Each cycle with `y_valid`=1: `mem[count]` ← `y_in` and `count`++.
  - `peak_abs` ← max(`peak_abs`, |`y_in`|). |−2^(DATA_W−1)| saturates to 2^(DATA_W−1)−1.
  - `clip_cnt`++ if `y_in` is 2^(DATA_W−1)−1 or −2^(DATA_W−1).
  - The write that makes `count`=DEPTH → DONE.
  - `arm` is ignored in CAPTURE.
- **DONE**
  - `y_valid` is ignored; memory is frozen.
  - `arm`=1 → CAPTURE with the same clears. Old contents are overwritten progressively.
- **Reads**
  - Served only in DONE.
  - `rd_en`=1 in DONE → `rd_data`=`mem[rd_addr]` and `rd_valid`=1 on the next cycle.
  - `rd_addr` ≥ DEPTH returns 0 with `rd_valid`=1.
  - `rd_en` outside DONE: `rd_valid` stays 0 and `rd_data` holds its last value.
  - Back-to-back `rd_en` gives one result per cycle.
  - `rd_en` together with `arm` in DONE: the read is served from pre-arm contents (the read completes before any new write can land).
- Memory is single write port, single registered read port; it infers as block RAM. Contents are not cleared by reset or arm.

## Timing
- Reset values: state IDLE, `busy`=0, `done`=0, `count`=0, `peak_abs`=0, `clip_cnt`=0, `rd_data`=0, `rd_valid`=0.
- `arm` at cycle k in IDLE/DONE → `busy`=1 at k+1.
  - A sample with `y_valid` at cycle k is not captured.
  - The first capturable sample is at k+1.
- Sample accepted at cycle k → `count`, `peak_abs`, `clip_cnt` updated at k+1.
- DEPTH-th sample at cycle k → `busy`=0, `done`=1, `count`=DEPTH at k+1.
- Read latency is exactly 1 cycle: `rd_en` at k → `rd_valid` at k+1. This holds even if state leaves DONE at k+1.
- `rst` mid-capture → IDLE next cycle, all outputs at reset values. Partial data is abandoned.
- `y_valid` gaps of any length in CAPTURE are legal; capture simply waits.
- `rst` has priority over `arm` in the same cycle.

## Test plan
- **Reset and idle:** hold `rst` 10 cycles, then drive `y_valid`=1 with samples and no arm → all outputs 0, `count` stays 0.
- **Full capture:** DEPTH=8; arm, then feed 8 samples 1, −2, 3, −4, 5, −6, 7, −8 with `y_valid` continuous.
  - Required: `done` rises exactly 1 cycle after the 8th sample, `count`=8, `peak_abs`=8, `clip_cnt`=0.
  - Reading addresses 0..7 back-to-back returns the same 8 values, `rd_valid` high 8 consecutive cycles.
- **Gapped stream and clipping:** DEPTH=8; `y_valid` alternating 1/0; samples include 32767, −32768 and −32768.
  - Required: `clip_cnt`=3, `peak_abs`=32767, `done` after 8 valid samples (about 16 cycles).
- **Arm/valid same cycle:** arm and `y_valid`=1 with `y_in`=100 at cycle k, then `y_in`=200 at k+1 → `mem[0]`=200.
- **Reset mid-capture:** assert `rst` after 4 of 8 samples → next cycle `busy`=0, `count`=0, `peak_abs`=0. A re-arm then captures a fresh 8.
- **Read gating and re-arm:**
  - `rd_en` during CAPTURE → `rd_valid`=0.
  - In DONE, `rd_en`(addr 2) with `arm` in the same cycle → `rd_valid`=1 with the old `mem[2]`, and `busy`=1 next cycle.
